// File: rtl/tug_match_ctrl.sv
// Match sequencer for the tug-of-war game: counts round wins, pulses the round reset
// between rounds, gates play while a result is shown and declares the match winner.
module tug_match_ctrl #(
    parameter int WIN_TARGET  = 3,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       P1win,
    input  logic       P2win,
    output logic       roundReset,
    output logic       playEnable,
    output logic [2:0] p1Score,
    output logic [2:0] p2Score,
    output logic [6:0] hexP1,
    output logic [6:0] hexP2,
    output logic       matchOver,
    output logic [1:0] matchWinner
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    TARGET    = 3'(WIN_TARGET);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_HOLD  = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] hold_cnt_r;
    logic [CW-1:0] hold_cnt_next_s;
    logic [2:0]    p1_next_s;
    logic [2:0]    p2_next_s;
    logic [1:0]    winner_next_s;

    // Active-low gfedcba segment pattern for one score digit.
    function automatic logic [6:0] hex7(input logic [2:0] value);
        logic [6:0] seg;
        case (value)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            3'd7:    seg = 7'b1111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Moore decode {roundReset, playEnable, matchOver} for a given state.
    function automatic logic [2:0] state_outputs(input state_t st);
        logic [2:0] o;
        case (st)
            S_IDLE:  o = 3'b100;
            S_PLAY:  o = 3'b010;
            S_HOLD:  o = 3'b000;
            S_CLEAR: o = 3'b100;
            S_DONE:  o = 3'b001;
            default: o = 3'b100;
        endcase
        return o;
    endfunction

    // Next-state, score, hold counter and winner selection.
    always_comb begin
        state_next_s    = state_r;
        hold_cnt_next_s = hold_cnt_r;
        p1_next_s       = p1Score;
        p2_next_s       = p2Score;
        winner_next_s   = matchWinner;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    state_next_s = S_PLAY;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_PLAY: begin
                if (P1win && !P2win) begin
                    p1_next_s       = p1Score + 3'd1;
                    hold_cnt_next_s = '0;
                    state_next_s    = S_HOLD;
                end else if (P2win && !P1win) begin
                    p2_next_s       = p2Score + 3'd1;
                    hold_cnt_next_s = '0;
                    state_next_s    = S_HOLD;
                end else begin
                    state_next_s = S_PLAY;
                end
            end
            S_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    hold_cnt_next_s = '0;
                    if ((p1Score == TARGET) || (p2Score == TARGET)) begin
                        state_next_s  = S_DONE;
                        winner_next_s = (p1Score == TARGET) ? 2'b01 : 2'b10;
                    end else begin
                        state_next_s = S_CLEAR;
                    end
                end else begin
                    hold_cnt_next_s = hold_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_CLEAR: begin
                state_next_s = S_PLAY;
            end
            S_DONE: begin
                if (Start) begin
                    state_next_s  = S_IDLE;
                    p1_next_s     = 3'd0;
                    p2_next_s     = 3'd0;
                    winner_next_s = 2'b00;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s    = S_IDLE;
                hold_cnt_next_s = '0;
                p1_next_s       = 3'd0;
                p2_next_s       = 3'd0;
                winner_next_s   = 2'b00;
            end
        endcase
    end

    // State, scores and registered outputs; outputs load from the next state so they
    // change on the same edge as the state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= S_IDLE;
            hold_cnt_r  <= '0;
            p1Score     <= 3'd0;
            p2Score     <= 3'd0;
            matchWinner <= 2'b00;
            hexP1       <= 7'b1000000;
            hexP2       <= 7'b1000000;
            roundReset  <= 1'b1;
            playEnable  <= 1'b0;
            matchOver   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            hold_cnt_r  <= hold_cnt_next_s;
            p1Score     <= p1_next_s;
            p2Score     <= p2_next_s;
            matchWinner <= winner_next_s;
            hexP1       <= hex7(p1_next_s);
            hexP2       <= hex7(p2_next_s);
            {roundReset, playEnable, matchOver} <= state_outputs(state_next_s);
        end
    end

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Self-checking bench for tug_match_ctrl: directed vector table, corner sequences,
// and randomized play against a round/timeline reference model.
module tb_tug_match_ctrl;

    localparam int T = 3;
    localparam int H = 8;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       P1win;
    logic       P2win;
    logic       roundReset;
    logic       playEnable;
    logic [2:0] p1Score;
    logic [2:0] p2Score;
    logic [6:0] hexP1;
    logic [6:0] hexP2;
    logic       matchOver;
    logic [1:0] matchWinner;

    int checks = 0;
    int errors = 0;

    tug_match_ctrl #(.WIN_TARGET(T), .HOLD_CYCLES(H)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .P1win(P1win), .P2win(P2win),
        .roundReset(roundReset), .playEnable(playEnable),
        .p1Score(p1Score), .p2Score(p2Score), .hexP1(hexP1), .hexP2(hexP2),
        .matchOver(matchOver), .matchWinner(matchWinner)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: match in progress, result display countdown, clearing flag.
    bit m_active, m_done, m_clr;
    int m_show, m_s1, m_s2, m_win;

    function automatic logic [6:0] hex_ref(input int v);
        logic [6:0] tbl [8];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100; tbl[3] = 7'b0110000;
        tbl[4] = 7'b0011001; tbl[5] = 7'b0010010; tbl[6] = 7'b0000010; tbl[7] = 7'b1111000;
        return tbl[v & 7];
    endfunction

    task automatic model(input logic r, s, a, b);
        if (r) begin
            m_active = 0; m_done = 0; m_clr = 0; m_show = 0;
            m_s1 = 0; m_s2 = 0; m_win = 0;
        end else if (!m_active) begin
            if (s) m_active = 1;
        end else if (m_done) begin
            if (s) begin
                m_active = 0; m_done = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
            end
        end else if (m_show > 0) begin
            m_show--;
            if (m_show == 0) begin
                if (m_s1 == T || m_s2 == T) begin
                    m_done = 1;
                    m_win  = (m_s1 == T) ? 1 : 2;
                end else begin
                    m_clr = 1;
                end
            end
        end else if (m_clr) begin
            m_clr = 0;
        end else begin
            if (a && !b) begin m_s1++; m_show = H; end
            else if (b && !a) begin m_s2++; m_show = H; end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("roundReset", int'(roundReset), int'(!m_active || m_clr));
        check("playEnable", int'(playEnable), int'(m_active && !m_done && m_show == 0 && !m_clr));
        check("matchOver", int'(matchOver), int'(m_done));
        check("p1Score", int'(p1Score), m_s1);
        check("p2Score", int'(p2Score), m_s2);
        check("hexP1", int'(hexP1), int'(hex_ref(m_s1)));
        check("hexP2", int'(hexP2), int'(hex_ref(m_s2)));
        check("matchWinner", int'(matchWinner), m_win);
    endtask

    task automatic step(input logic r, s, a, b);
        Reset = r; Start = s; P1win = a; P2win = b;
        @(posedge Clock);
        model(r, s, a, b);
        #1;
        check_model();
    endtask

    task automatic wait_play();
        int n = 0;
        while (!playEnable && n < 40) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check("wait_play_timeout", int'(playEnable), 1);
    endtask

    typedef struct {
        logic r, s, a, b;
        logic rr, pe;
        int   p1, p2;
    } vec_t;

    function automatic vec_t mk(input logic r, s, a, b, rr, pe, input int p1, p2);
        vec_t v;
        v.r = r; v.s = s; v.a = a; v.b = b; v.rr = rr; v.pe = pe; v.p1 = p1; v.p2 = p2;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        Reset = 1'b1; Start = 1'b0; P1win = 1'b0; P2win = 1'b0;
        m_active = 0; m_done = 0; m_clr = 0; m_show = 0; m_s1 = 0; m_s2 = 0; m_win = 0;

        // Directed table: expected values are the outputs after each edge.
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < H - 1; i++)
            tbl.push_back(mk(0, (i == 2) ? 1'b1 : 1'b0, (i > 3) ? 1'b1 : 1'b0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_roundReset", i), int'(roundReset), int'(tbl[i].rr));
            check($sformatf("tbl%0d_playEnable", i), int'(playEnable), int'(tbl[i].pe));
            check($sformatf("tbl%0d_p1Score", i), int'(p1Score), tbl[i].p1);
            check($sformatf("tbl%0d_p2Score", i), int'(p2Score), tbl[i].p2);
            if (i == 1) begin
                check("reset_hexP1", int'(hexP1), int'(7'b1000000));
                check("reset_hexP2", int'(hexP2), int'(7'b1000000));
                check("reset_winner", int'(matchWinner), 0);
            end
            if (i == 4) check("win1_hexP1", int'(hexP1), int'(7'b1111001));
        end

        // Two more P1 rounds take the match.
        for (int k = 0; k < 2; k++) begin
            wait_play();
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < H; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("done_matchOver", int'(matchOver), 1);
        check("done_winner", int'(matchWinner), 1);
        check("done_hexP1", int'(hexP1), int'(7'b0110000));
        check("done_roundReset", int'(roundReset), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("done_hold_roundReset", int'(roundReset), 0);
        check("done_hold_p1", int'(p1Score), 3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("ack_p1", int'(p1Score), 0);
        check("ack_p2", int'(p2Score), 0);
        check("ack_winner", int'(matchWinner), 0);
        check("ack_roundReset", int'(roundReset), 1);

        // Reset on HOLD cycle 4 with p2Score=2.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_play();
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("midhold_p2", int'(p2Score), 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("midhold_rst_p2", int'(p2Score), 0);
        check("midhold_rst_roundReset", int'(roundReset), 1);
        check("midhold_rst_playEnable", int'(playEnable), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("midhold_idle_stays", int'(roundReset), 1);

        // Randomized play; a fresh hold after the reset also exercises the counter restart.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
